// File: rtl/vic_pkg.sv
// vic_pkg: shared definitions for the vectored interrupt controller.
//   VEC_W          - width of one interrupt vector lane
//   vic_state_t    - bus handshake state (IDLE, ACK)
//   lowest_set_idx - index of the least significant set bit of a 16-bit word
package vic_pkg;

  localparam int VEC_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } vic_state_t;

  // Returns 0 when no bit is set; callers qualify with their own valid flag.
  function automatic int lowest_set_idx(input logic [15:0] v);
    int idx;
    idx = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vic_prio_arb.sv
// vic_prio_arb: combinational priority encoder over the unmasked pending bits.
// Optional feature macro: VIC_ROTATE_EN
//   undefined - fixed priority, channel 0 highest, no ptr input
//   defined   - rotating priority, search starts at ptr and wraps
// Ports:
//   req   in  N   pending & ~mask
//   ptr   in  IW  highest-priority channel (rotating build only)
//   sel   out IW  winning channel index
//   valid out 1   at least one request present
module vic_prio_arb
  import vic_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
`ifdef VIC_ROTATE_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [IW-1:0] sel,
  output logic          valid
);

`ifdef VIC_ROTATE_EN
  logic [15:0] rot_s;
  int          idx_s;

  // Rotate requests so that channel ptr lands on bit 0, encode, then rotate the index back.
  always_comb begin
    rot_s = 16'h0000;
    for (int i = 0; i < N; i++) begin
      rot_s[i] = req[IW'((i + int'(ptr)) % N)];
    end
    idx_s = lowest_set_idx(rot_s);
    sel   = IW'((idx_s + int'(ptr)) % N);
    valid = |req;
  end
`else
  logic [15:0] req_pad_s;

  // Zero-extend to a fixed 16-bit lane and take the lowest set index.
  always_comb begin
    req_pad_s          = 16'h0000;
    req_pad_s[N-1:0]   = req;
    sel                = IW'(lowest_set_idx(req_pad_s));
    valid              = |req;
  end
`endif

endmodule

// File: rtl/vic_prio_wb.sv
// vic_prio_wb: vectored interrupt controller with a wishbone-style vector read.
// Peripherals raise edge-latched requests; the CPU sees wb_irq_o, strobes a
// vector read and gets the vector of the winning channel, which in turn
// receives a one-ce-tick iack pulse. An empty strobe returns SPUR_VEC.
// Optional feature macro: VIC_ROTATE_EN (rotating priority with ptr register).
// Ports:
//   clk_sys  in  1     system clock
//   rst_n    in  1     asynchronous active-low reset
//   ce       in  1     bus clock-enable, all state moves only when high
//   wb_rst_i in  1     synchronous soft reset, sampled on ce
//   ivec     in  N*16  per-channel vectors, channel i at [16*i+15:16*i]
//   ireq     in  N     request lines, rising edge requests service
//   imask    in  N     1 = channel masked (pending bit retained)
//   wb_stb_i in  1     vector read strobe
//   wb_ack_o out 1     vector read acknowledge
//   wb_dat_o out 16    vector, zero while wb_ack_o is low
//   wb_irq_o out 1     interrupt request to the CPU
//   iack     out N     one-ce-tick service pulse to the served channel
module vic_prio_wb
  import vic_pkg::*;
#(
  parameter int               N        = 2,
  parameter logic [VEC_W-1:0] SPUR_VEC = 16'o000000
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 wb_rst_i,
  input  logic [N*VEC_W-1:0]   ivec,
  input  logic [N-1:0]         ireq,
  input  logic [N-1:0]         imask,
  input  logic                 wb_stb_i,
  output logic                 wb_ack_o,
  output logic [VEC_W-1:0]     wb_dat_o,
  output logic                 wb_irq_o,
  output logic [N-1:0]         iack
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     pending_r;
  logic [N-1:0]     ireq_q_r;
  vic_state_t       state_r;
  vic_state_t       state_nx_s;

  logic [N-1:0]     req_s;
  logic [N-1:0]     rise_s;
  logic [N-1:0]     clr_s;
  logic [N-1:0]     iack_nx_s;
  logic             ack_nx_s;
  logic [VEC_W-1:0] dat_nx_s;
  logic [IW-1:0]    sel_s;
  logic             valid_s;
  logic [VEC_W-1:0] vec_s [N];

`ifdef VIC_ROTATE_EN
  logic [IW-1:0]    ptr_r;
  logic [IW-1:0]    ptr_nx_s;
`endif

  assign req_s  = pending_r & ~imask;
  assign rise_s = ireq & ~ireq_q_r;

  for (genvar g = 0; g < N; g++) begin : g_vec
    assign vec_s[g] = ivec[g*VEC_W +: VEC_W];
  end

  vic_prio_arb #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req   (req_s),
`ifdef VIC_ROTATE_EN
    .ptr   (ptr_r),
`endif
    .sel   (sel_s),
    .valid (valid_s)
  );

  // Next-state and next-output decode for the strobe/ack handshake.
  always_comb begin
    state_nx_s = state_r;
    ack_nx_s   = wb_ack_o;
    dat_nx_s   = wb_dat_o;
    iack_nx_s  = {N{1'b0}};
    clr_s      = {N{1'b0}};
`ifdef VIC_ROTATE_EN
    ptr_nx_s   = ptr_r;
`endif
    case (state_r)
      IDLE: begin
        if (wb_stb_i) begin
          state_nx_s = ACK;
          ack_nx_s   = 1'b1;
          if (valid_s) begin
            dat_nx_s         = vec_s[sel_s];
            iack_nx_s[sel_s] = 1'b1;
            clr_s[sel_s]     = 1'b1;
`ifdef VIC_ROTATE_EN
            if (sel_s == IW'(N - 1)) begin
              ptr_nx_s = {IW{1'b0}};
            end else begin
              ptr_nx_s = sel_s + IW'(1);
            end
`endif
          end else begin
            // Spurious read still acks so the bus never hangs.
            dat_nx_s = SPUR_VEC;
          end
        end else begin
          ack_nx_s = 1'b0;
          dat_nx_s = {VEC_W{1'b0}};
        end
      end
      ACK: begin
        // iack already defaults to zero here, so the pulse is one ce period.
        if (!wb_stb_i) begin
          state_nx_s = IDLE;
          ack_nx_s   = 1'b0;
          dat_nx_s   = {VEC_W{1'b0}};
        end else begin
          state_nx_s = ACK;
        end
      end
      default: begin
        state_nx_s = IDLE;
        ack_nx_s   = 1'b0;
        dat_nx_s   = {VEC_W{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (ce) begin
      if (wb_rst_i) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_nx_s;
      end
    end else begin
      state_r <= state_r;
    end
  end

  // Registered bus outputs and service pulse.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= {VEC_W{1'b0}};
      iack     <= {N{1'b0}};
    end else if (ce) begin
      if (wb_rst_i) begin
        wb_ack_o <= 1'b0;
        wb_dat_o <= {VEC_W{1'b0}};
        iack     <= {N{1'b0}};
      end else begin
        wb_ack_o <= ack_nx_s;
        wb_dat_o <= dat_nx_s;
        iack     <= iack_nx_s;
      end
    end else begin
      wb_ack_o <= wb_ack_o;
      wb_dat_o <= wb_dat_o;
      iack     <= iack;
    end
  end

  // Edge latch: a new rising edge beats a same-tick service clear.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N{1'b0}};
      ireq_q_r  <= {N{1'b0}};
    end else if (ce) begin
      if (wb_rst_i) begin
        pending_r <= {N{1'b0}};
        ireq_q_r  <= {N{1'b0}};
      end else begin
        pending_r <= (pending_r & ~clr_s) | rise_s;
        ireq_q_r  <= ireq;
      end
    end else begin
      pending_r <= pending_r;
      ireq_q_r  <= ireq_q_r;
    end
  end

  // Interrupt line follows the unmasked pending set one tick later.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wb_irq_o <= 1'b0;
    end else if (ce) begin
      if (wb_rst_i) begin
        wb_irq_o <= 1'b0;
      end else begin
        wb_irq_o <= |req_s;
      end
    end else begin
      wb_irq_o <= wb_irq_o;
    end
  end

`ifdef VIC_ROTATE_EN
  // Rotating-priority pointer, advanced past each served channel.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IW{1'b0}};
    end else if (ce) begin
      if (wb_rst_i) begin
        ptr_r <= {IW{1'b0}};
      end else begin
        ptr_r <= ptr_nx_s;
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

endmodule

// File: doc/vic_prio_wb.md
Name: vic_prio_wb

Overview:
- Parametrised vectored interrupt controller for the BK CPU's virq/iako vector fetch.
- Supports N request channels with edge-latched pending bits and a per-channel mask.
- A priority arbiter selects the channel to serve; the selected vector is returned on a wishbone-style strobe/ack read, and a one-tick acknowledge pulse goes back to the requesting peripheral.
- Sits between peripherals (timer, keyboard, disk) and the CPU's pin_virq / iako vector read path, on the bus clock-enable.

Parameters:
- N, 2, number of request channels (1..16); channel 0 is highest fixed priority.
- SPUR_VEC, 16'o000000, vector returned when strobed with nothing pending.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  bus clock-enable; all state updates only on clk_sys edges with ce=1
- wb_rst_i  in  1  synchronous soft reset (bus INIT), sampled on ce
- ivec  in  N*16  per-channel vectors; channel i at [16*i+15:16*i]
- ireq  in  N  request lines; rising edge requests service
- imask  in  N  1 = channel masked; its pending bit is kept
- wb_stb_i  in  1  vector read strobe (iako & read & bus strobe)
- wb_ack_o  out  1  vector read acknowledge
- wb_dat_o  out  16  vector; 0 whenever wb_ack_o=0
- wb_irq_o  out  1  virq to CPU
- iack  out  N  one-ce-tick service pulse to the served channel

Behaviour:
- Reset:
  - rst_n=0 asynchronously clears pending, ireq sample register, FSM (IDLE), wb_ack_o, wb_dat_o, wb_irq_o, iack.
  - wb_rst_i=1 on a ce tick performs the same clear synchronously and overrides every other event that tick.
- Edge latch:
  - ireq is sampled every ce tick; pending[i] is set when sample was 0 and ireq[i]=1.
  - Set and clear of the same bit on the same tick: set wins (the new edge re-pends).
  - A level held high does not re-request.
- wb_irq_o is registered, equal to |(pending & ~imask), and updates on the ce tick after pending or imask changes.
- Arbiter (combinational): sel = lowest index i with pending[i] & ~imask[i]; valid = any such bit.
- FSM states IDLE and ACK:
  - IDLE, ce, wb_stb_i=1 -> ACK. On that tick:
    - wb_ack_o<=1.
    - wb_dat_o<=valid ? ivec[sel] : SPUR_VEC.
    - If valid, iack[sel]<=1 and pending[sel] cleared.
    - Arbitration uses pending before any same-tick edge.
  - ACK, ce: iack<=0 unconditionally, giving exactly one ce period. If wb_stb_i=0, wb_ack_o<=0, wb_dat_o<=0, -> IDLE; otherwise hold.
- Latency:
  - Strobe sampled at tick k -> ack/data valid after tick k; release one tick after stb drops.
  - Back-to-back strobes are serviced only after returning to IDLE.
- wb_irq_o may deassert during ACK if no other channel is pending; it is not forced low by the FSM.
- A spurious strobe always acks (no bus hang) and never pulses iack.
- Width: N=1 is legal (arbiter degenerates); ivec slicing uses fixed 16-bit lanes.

Optional Feature:
- VIC_ROTATE_EN:
  - Defined: rotating priority. A ptr register (reset 0) marks the highest-priority channel; after a valid service of channel s, ptr<=(s+1) mod N. The arbiter searches from ptr upward with wrap.
  - Undefined: fixed priority, channel 0 highest, and no ptr register.

Decomposition:
- Package vic_pkg:
  - VEC_W=16 localparam.
  - vic_state_t enum {IDLE, ACK}.
  - Function for the lowest-set-bit index.
- Sub-module vic_prio_arb (inputs pending&~imask and ptr; outputs sel, valid): a pure combinational priority / rotating encoder. Rotation is instantiated only under VIC_ROTATE_EN.

Test Plan:
- Reset: hold rst_n=0 mid-ACK with pending=4'b1010 -> all outputs 0 immediately; after release, wb_irq_o stays 0 with ireq static.
- N=4, ivec={0104,0100,0274,060}: ireq[1] rises -> wb_irq_o=1 next ce. Then stb -> wb_dat_o=16'o000274, wb_ack_o=1, iack=4'b0010 for one ce, wb_irq_o=0 afterwards.
- ireq[0] and ireq[2] rise on the same tick -> first read returns 060 and second returns 0100 (fixed mode). With VIC_ROTATE_EN and ch0/ch1 re-requested after each service -> reads alternate 060, 0274.
- imask[0]=1, ireq[0] rises -> wb_irq_o stays 0. Clearing imask[0] -> wb_irq_o=1 one tick later; stb returns 060.
- stb with nothing pending -> wb_ack_o=1, wb_dat_o=SPUR_VEC, iack=0.
- wb_rst_i=1 during ACK with ch2 pending -> next ce ack=0, dat=0, pending cleared, FSM IDLE. An ireq edge coinciding with a pending clear keeps the bit set.
